mips_cpu_cache_wbuf_coalesce: RTL and testbench
===============================================

// Module: mips_cpu_cache_wbuf_coalesce
// PURPOSE
//  Parametrised posted-write buffer between the data cache and the Avalon-MM data master.
//  Queues CPU stores in FIFO order and drains them to memory under waitrequest.
//  Merges a store into a queued, not-yet-issued entry for the same word (byte-lane coalescing).
//  Provides a combinational snoop port so read misses can forward pending store bytes.
// PARAMETERS
//  DEPTH     8    entries; power of 2, >=2
//  ADDR_W    32   byte-address width; word address is addr[ADDR_W-1:2]
//  DATA_W    32   data width; BE_W = DATA_W/8 byte lanes
//  COALESCE  1    1 = merge same-word stores; 0 = strict one-entry-per-store FIFO
// PORTS
//  clk               in   1        clock
//  rst_n             in   1        asynchronous active-low reset
//  in_valid          in   1        cache presents a store this cycle
//  in_ready          out  1        store accepted on clk edge when in_valid&in_ready
//  in_addr           in   ADDR_W   store byte address (bits [1:0] ignored)
//  in_data           in   DATA_W   store data, lane-aligned
//  in_byteenable     in   BE_W     lanes written
//  drain_en          in   1        0 = do not start new memory writes (read-miss priority)
//  snoop_addr        in   ADDR_W   read-miss address to check
//  snoop_hit         out  1        >=1 valid entry matches snoop word
//  snoop_data        out  DATA_W   pending bytes for that word, youngest wins per lane
//  snoop_byteenable  out  BE_W     lanes covered by pending stores
//  avm_address       out  ADDR_W   head entry word address, bits [1:0]=0
//  avm_write         out  1        Avalon write request
//  avm_writedata     out  DATA_W   head entry data
//  avm_byteenable    out  BE_W     head entry byte enables
//  avm_waitrequest   in   1        slave stall
//  count             out  $clog2(DEPTH)+1  valid entries
//  full              out  1        count==DEPTH
//  empty             out  1        count==0
// BEHAVIOUR
//  Reset (async, rst_n=0): all valid bits 0, head=tail=0, issued=0; outputs: in_ready=1,
//   avm_write=0, snoop_hit=0, snoop_byteenable=0, count=0, empty=1, full=0. avm_address/
//   writedata/byteenable=0. Reset mid-transaction drops all entries and any in-flight write.
//  Storage: circular buffer, head/tail pointers with wrap bit; count = tail-head.
//  Push: on edge with in_valid&in_ready. If COALESCE and an unlocked valid entry matches the
//   word address: entry.data lanes with in_byteenable=1 replaced, entry.be |= in_byteenable,
//   no tail move. Else write at tail, tail+1 (wraps modulo DEPTH). Store visible to avm and
//   snoop from next cycle (latency 1); no same-cycle bypass.
//  Lock: head entry is locked once avm_write is asserted for it; never coalesced into.
//   At most one unlocked entry per word exists (the newest), so the merge target is unique.
//  in_ready = !full | (COALESCE & unlocked match). Pop in same cycle never frees space for push.
//  Drain FSM: IDLE -> ISSUE when !empty & drain_en; in ISSUE avm_write=1 and address/data/be
//   driven from head, held stable while avm_waitrequest=1 regardless of drain_en (Avalon rule).
//   On edge with avm_waitrequest=0: head valid cleared, head+1; stay ISSUE if remaining entries
//   and drain_en (back-to-back, next entry presented next cycle), else IDLE.
//   drain_en=0 only prevents starting a new write.
//  Simultaneous push+pop: both apply; count unchanged; full case: push only if coalescing.
//  Push matching the head while head issues: allocates a new tail entry (head locked).
//  Snoop: combinational over all valid entries; per lane, youngest matching entry with that
//   lane enabled supplies data; snoop_byteenable = OR of matching entries' be. Entry popped
//   on this edge still reported this cycle.
//  Stores with in_byteenable=0 are accepted and dropped (no allocation, no merge).
// STRUCTURE
//  Package mips_cpu_wbuf_pkg: wbuf_state_t {WB_IDLE, WB_ISSUE}; parametrised entry struct
//   (valid, waddr, data, be); function merge_lanes(old_data, new_data, be).
//  Sub-module mips_cpu_wbuf_match: DEPTH-way word-address comparator returning one-hot
//   unlocked-match vector and age-ordered match vector (used by push merge and snoop).
// TESTING
//  1 Reset with 3 entries queued and avm_write=1 mid-wait -> avm_write=0, empty=1, count=0 immediately.
//  2 Push 0x100/0x11223344/be=F, 0x104/0xAABBCCDD/F, drain_en=1, waitrequest 2 cycles each ->
//    avm sees 0x100 then 0x104, fields stable during wait, empty=1 after second accept.
//  3 drain_en=0: push 0x200 be=0001 data 0x000000AA, then 0x200 be=1000 data 0xBB000000 ->
//    count=1, entry 0xBB0000AA be=1001; snoop 0x200 -> hit=1, be=1001; snoop 0x204 -> hit=0.
//  4 Head 0x300 issuing with waitrequest=1, push 0x300 be=F -> new entry, count=2, both written in order.
//  5 DEPTH=8 fill 8 distinct words, drain_en=0 -> full=1, in_ready=0; push 9th distinct held;
//    push matching queued word accepted (merge); drain_en=1, one accept -> in_ready=1.
//  6 COALESCE=0: two stores to 0x400 -> count=2, two Avalon writes; snoop lanes youngest-wins.

Source files
------------

// File: rtl/mips_cpu_wbuf_pkg.sv
// Shared types and helpers for the posted-write buffer.
//   wbuf_state_t : drain FSM states
//   merge_lanes  : byte-lane merge of new store data over old entry data
//                  (operates at a maximum width; callers cast to/from DATA_W)
package mips_cpu_wbuf_pkg;

  typedef enum logic [0:0] {WB_IDLE = 1'b0, WB_ISSUE = 1'b1} wbuf_state_t;

  localparam int WB_MAX_DW = 64;
  localparam int WB_MAX_BE = WB_MAX_DW / 8;

  function automatic logic [WB_MAX_DW-1:0] merge_lanes(
    input logic [WB_MAX_DW-1:0] old_data,
    input logic [WB_MAX_DW-1:0] new_data,
    input logic [WB_MAX_BE-1:0] be
  );
    logic [WB_MAX_DW-1:0] r;
    for (int i = 0; i < WB_MAX_BE; i++)
      r[i*8 +: 8] = be[i] ? new_data[i*8 +: 8] : old_data[i*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/mips_cpu_wbuf_match.sv
// DEPTH-way word-address comparator for the write buffer.
//   vld_i/waddr_i : per-entry valid and word address
//   lock_i        : entries that must not be merged into (issuing head)
//   addr_i        : word address to compare
//   head_i        : index of the oldest entry
//   umatch_o      : by entry index, valid & unlocked & address match
//   age_match_o   : all valid matches, bit k = k-th oldest entry (bit 0 = head)
module mips_cpu_wbuf_match #(
  parameter int DEPTH = 8,
  parameter int WA_W  = 30,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]           vld_i,
  input  logic [DEPTH-1:0][WA_W-1:0] waddr_i,
  input  logic [DEPTH-1:0]           lock_i,
  input  logic [WA_W-1:0]            addr_i,
  input  logic [PTR_W-1:0]           head_i,
  output logic [DEPTH-1:0]           umatch_o,
  output logic [DEPTH-1:0]           age_match_o
);

  logic [DEPTH-1:0] match;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign match[i] = vld_i[i] && (waddr_i[i] == addr_i);
  end

  assign umatch_o = match & ~lock_i;

  // Rotate so that bit order follows age; pointer arithmetic wraps at DEPTH.
  always_comb begin
    age_match_o = '0;
    for (int k = 0; k < DEPTH; k++)
      age_match_o[k] = match[head_i + PTR_W'(k)];
  end

endmodule

// File: rtl/mips_cpu_cache_wbuf_coalesce.sv
// Posted-write buffer between the data cache and the Avalon-MM data master.
// Queues stores in FIFO order, merges stores into a queued not-yet-issued entry
// of the same word, drains to memory under waitrequest, and offers a
// combinational snoop so read misses can forward pending store bytes.
//   in_*      : store request from the cache (valid/ready handshake)
//   drain_en  : 0 blocks the start of new memory writes
//   snoop_*   : read-miss address in, pending bytes/lanes out
//   avm_*     : Avalon-MM write master
//   count/full/empty : occupancy
module mips_cpu_cache_wbuf_coalesce
  import mips_cpu_wbuf_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int COALESCE = 1,
  localparam int BE_W  = DATA_W / 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1,
  localparam int WA_W  = ADDR_W - 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [BE_W-1:0]   in_byteenable,
  input  logic              drain_en,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              snoop_hit,
  output logic [DATA_W-1:0] snoop_data,
  output logic [BE_W-1:0]   snoop_byteenable,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [BE_W-1:0]   avm_byteenable,
  input  logic              avm_waitrequest,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  typedef struct packed {
    logic              valid;
    logic [WA_W-1:0]   waddr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } entry_t;

  entry_t [DEPTH-1:0] ent_q;
  logic [PTR_W:0]     head_q, tail_q, head_d, tail_d;
  wbuf_state_t        state_q;

  logic [DEPTH-1:0]           ent_vld, lock;
  logic [DEPTH-1:0][WA_W-1:0] ent_waddr;
  logic [DEPTH-1:0]           push_umatch, push_age, snp_umatch, snp_age;
  logic [PTR_W-1:0]           head_idx, tail_idx, snp_idx;
  logic                       hit_u, push, merge, alloc, pop;
  logic                       unused_ok;

  assign head_idx = head_q[PTR_W-1:0];
  assign tail_idx = tail_q[PTR_W-1:0];

  always_comb begin
    lock = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_vld[i]   = ent_q[i].valid;
      ent_waddr[i] = ent_q[i].waddr;
    end
    // The head is frozen once presented on the bus.
    if (state_q == WB_ISSUE) lock[head_idx] = 1'b1;
  end

  mips_cpu_wbuf_match #(.DEPTH(DEPTH), .WA_W(WA_W)) u_push_match (
    .vld_i(ent_vld), .waddr_i(ent_waddr), .lock_i(lock),
    .addr_i(in_addr[ADDR_W-1:2]), .head_i(head_idx),
    .umatch_o(push_umatch), .age_match_o(push_age)
  );

  mips_cpu_wbuf_match #(.DEPTH(DEPTH), .WA_W(WA_W)) u_snoop_match (
    .vld_i(ent_vld), .waddr_i(ent_waddr), .lock_i(lock),
    .addr_i(snoop_addr[ADDR_W-1:2]), .head_i(head_idx),
    .umatch_o(snp_umatch), .age_match_o(snp_age)
  );

  assign unused_ok = ^{push_age, snp_umatch, in_addr[1:0], snoop_addr[1:0]};

  assign count = tail_q - head_q;
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // At most one unlocked entry per word exists, so push_umatch is one-hot.
  assign hit_u    = (COALESCE != 0) && (|push_umatch);
  assign in_ready = !full || hit_u;
  assign push     = in_valid && in_ready && (|in_byteenable);
  assign merge    = push && hit_u;
  assign alloc    = push && !merge;
  assign pop      = (state_q == WB_ISSUE) && !avm_waitrequest;
  assign tail_d   = tail_q + {{PTR_W{1'b0}}, alloc};
  assign head_d   = head_q + {{PTR_W{1'b0}}, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      state_q <= WB_IDLE;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (pop) ent_q[head_idx].valid <= 1'b0;
      if (alloc) begin
        ent_q[tail_idx].valid <= 1'b1;
        ent_q[tail_idx].waddr <= in_addr[ADDR_W-1:2];
        ent_q[tail_idx].data  <= in_data;
        ent_q[tail_idx].be    <= in_byteenable;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (merge && push_umatch[i]) begin
          ent_q[i].data <= DATA_W'(merge_lanes(WB_MAX_DW'(ent_q[i].data),
                                               WB_MAX_DW'(in_data),
                                               WB_MAX_BE'(in_byteenable)));
          ent_q[i].be   <= ent_q[i].be | in_byteenable;
        end
      end
      case (state_q)
        WB_IDLE:  if (!empty && drain_en) state_q <= WB_ISSUE;
        WB_ISSUE: if (pop) state_q <= ((tail_d != head_d) && drain_en) ? WB_ISSUE : WB_IDLE;
        default:  state_q <= WB_IDLE;
      endcase
    end
  end

  // Bus fields come straight from the locked head register, so they stay
  // stable for the whole waitrequest stall.
  assign avm_write      = (state_q == WB_ISSUE);
  assign avm_address    = avm_write ? {ent_q[head_idx].waddr, 2'b00} : '0;
  assign avm_writedata  = avm_write ? ent_q[head_idx].data : '0;
  assign avm_byteenable = avm_write ? ent_q[head_idx].be : '0;

  // Walk oldest to youngest so later matches overwrite lanes: youngest wins.
  always_comb begin
    snoop_data       = '0;
    snoop_byteenable = '0;
    snp_idx          = '0;
    for (int k = 0; k < DEPTH; k++) begin
      snp_idx = head_idx + PTR_W'(k);
      if (snp_age[k]) begin
        snoop_byteenable = snoop_byteenable | ent_q[snp_idx].be;
        for (int b = 0; b < BE_W; b++)
          if (ent_q[snp_idx].be[b]) snoop_data[b*8 +: 8] = ent_q[snp_idx].data[b*8 +: 8];
      end
    end
  end

  assign snoop_hit = |snp_age;

endmodule

// File: tb/tb_mips_cpu_cache_wbuf_coalesce.sv
module tb_mips_cpu_cache_wbuf_coalesce;

  logic        clk, rst_n;
  logic        in_valid, drain_en, avm_waitrequest;
  logic [31:0] in_addr, in_data, snoop_addr;
  logic [3:0]  in_byteenable;

  // coalescing instance
  logic        in_ready, snoop_hit, avm_write, full, empty;
  logic [31:0] snoop_data, avm_address, avm_writedata;
  logic [3:0]  snoop_byteenable, avm_byteenable, count;
  // strict FIFO instance
  logic        nc_in_ready, nc_snoop_hit, nc_avm_write, nc_full, nc_empty;
  logic [31:0] nc_snoop_data, nc_avm_address, nc_avm_writedata;
  logic [3:0]  nc_snoop_byteenable, nc_avm_byteenable, nc_count;

  int n_chk = 0;
  int n_err = 0;

  mips_cpu_cache_wbuf_coalesce #(.DEPTH(8), .ADDR_W(32), .DATA_W(32), .COALESCE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_byteenable(in_byteenable),
    .drain_en(drain_en), .snoop_addr(snoop_addr), .snoop_hit(snoop_hit),
    .snoop_data(snoop_data), .snoop_byteenable(snoop_byteenable),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
    .count(count), .full(full), .empty(empty)
  );

  mips_cpu_cache_wbuf_coalesce #(.DEPTH(8), .ADDR_W(32), .DATA_W(32), .COALESCE(0)) u_dut_nc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nc_in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_byteenable(in_byteenable),
    .drain_en(drain_en), .snoop_addr(snoop_addr), .snoop_hit(nc_snoop_hit),
    .snoop_data(nc_snoop_data), .snoop_byteenable(nc_snoop_byteenable),
    .avm_address(nc_avm_address), .avm_write(nc_avm_write), .avm_writedata(nc_avm_writedata),
    .avm_byteenable(nc_avm_byteenable), .avm_waitrequest(avm_waitrequest),
    .count(nc_count), .full(nc_full), .empty(nc_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    in_valid = 1'b1; in_addr = a; in_data = d; in_byteenable = be;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic snoop(input logic [31:0] a);
    snoop_addr = a;
    #1;
  endtask

  logic [31:0] wr_data [4];
  logic [3:0]  wr_be   [4];
  int          n_wr;
  int          guard;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; in_byteenable = '0;
    drain_en = 1'b0; snoop_addr = '0; avm_waitrequest = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_avm_write", avm_write, 0);
    chk("rst_avm_addr", avm_address, 0);
    snoop(32'h0);
    chk("rst_snoop_hit", snoop_hit, 0);
    chk("rst_snoop_be", snoop_byteenable, 0);

    // 1: reset mid-wait with three queued entries
    tick();
    push(32'h10, 32'h1, 4'hF);
    push(32'h14, 32'h2, 4'hF);
    push(32'h18, 32'h3, 4'hF);
    drain_en = 1'b1;
    tick();
    chk("t1_avm_write", avm_write, 1);
    chk("t1_count", count, 3);
    chk("t1_avm_addr", avm_address, 32'h10);
    #1 rst_n = 1'b0;
    #1;
    chk("t1_rst_avm_write", avm_write, 0);
    chk("t1_rst_empty", empty, 1);
    chk("t1_rst_count", count, 0);
    #1 rst_n = 1'b1;
    drain_en = 1'b0;
    tick();

    // 2: two stores drained with 2-cycle waitrequest each
    drain_en = 1'b1; avm_waitrequest = 1'b1;
    push(32'h100, 32'h11223344, 4'hF);
    push(32'h104, 32'hAABBCCDD, 4'hF);
    chk("t2_w1_write", avm_write, 1);
    chk("t2_w1_addr", avm_address, 32'h100);
    chk("t2_w1_data", avm_writedata, 32'h11223344);
    chk("t2_w1_be", avm_byteenable, 4'hF);
    tick();
    chk("t2_w1_addr_hold", avm_address, 32'h100);
    chk("t2_w1_data_hold", avm_writedata, 32'h11223344);
    avm_waitrequest = 1'b0;
    tick();
    avm_waitrequest = 1'b1;
    chk("t2_w2_write", avm_write, 1);
    chk("t2_w2_addr", avm_address, 32'h104);
    chk("t2_w2_data", avm_writedata, 32'hAABBCCDD);
    tick();
    chk("t2_w2_addr_hold", avm_address, 32'h104);
    avm_waitrequest = 1'b0;
    tick();
    avm_waitrequest = 1'b1;
    chk("t2_empty", empty, 1);
    chk("t2_idle", avm_write, 0);

    // 3: byte-lane merge with drain blocked, then snoop
    drain_en = 1'b0;
    push(32'h200, 32'h000000AA, 4'b0001);
    push(32'h200, 32'hBB000000, 4'b1000);
    chk("t3_count", count, 1);
    snoop(32'h200);
    chk("t3_snoop_hit", snoop_hit, 1);
    chk("t3_snoop_be", snoop_byteenable, 4'b1001);
    chk("t3_snoop_data", snoop_data, 32'hBB0000AA);
    snoop(32'h204);
    chk("t3_snoop_miss", snoop_hit, 0);
    drain_en = 1'b1; avm_waitrequest = 1'b0;
    tick();
    chk("t3_avm_data", avm_writedata, 32'hBB0000AA);
    chk("t3_avm_be", avm_byteenable, 4'b1001);
    tick();
    chk("t3_empty", empty, 1);
    drain_en = 1'b0; avm_waitrequest = 1'b1;

    // 4: store to the issuing head's word allocates a new entry
    drain_en = 1'b1;
    push(32'h300, 32'h33333333, 4'hF);
    tick();
    chk("t4_issue", avm_write, 1);
    push(32'h300, 32'h44444444, 4'hF);
    chk("t4_count", count, 2);
    chk("t4_head_data", avm_writedata, 32'h33333333);
    snoop(32'h300);
    chk("t4_snoop_young", snoop_data, 32'h44444444);
    avm_waitrequest = 1'b0;
    tick();
    avm_waitrequest = 1'b1;
    chk("t4_w2_addr", avm_address, 32'h300);
    chk("t4_w2_data", avm_writedata, 32'h44444444);
    avm_waitrequest = 1'b0;
    tick();
    avm_waitrequest = 1'b1;
    chk("t4_empty", empty, 1);
    drain_en = 1'b0;

    // 5: full buffer, blocked distinct push, accepted merge, one drain frees space
    for (int i = 0; i < 8; i++) push(32'h500 + 32'(4*i), 32'(i), 4'hF);
    chk("t5_full", full, 1);
    chk("t5_count", count, 8);
    in_valid = 1'b1; in_addr = 32'h600; in_data = 32'h66; in_byteenable = 4'hF;
    #1;
    chk("t5_ready_blocked", in_ready, 0);
    tick();
    chk("t5_count_held", count, 8);
    in_addr = 32'h504; in_data = 32'h0000FF00; in_byteenable = 4'b0010;
    #1;
    chk("t5_ready_merge", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("t5_count_merge", count, 8);
    snoop(32'h504);
    chk("t5_snoop_merged", snoop_data, 32'h0000FF01);
    drain_en = 1'b1; avm_waitrequest = 1'b1;
    tick();
    drain_en = 1'b0; avm_waitrequest = 1'b0;
    tick();
    avm_waitrequest = 1'b1;
    in_addr = 32'h600;
    #1;
    chk("t5_count_after_pop", count, 7);
    chk("t5_ready_after_pop", in_ready, 1);
    drain_en = 1'b1; avm_waitrequest = 1'b0;
    guard = 0;
    while (!empty && guard < 40) begin tick(); guard++; end
    chk("t5_drained", empty, 1);
    drain_en = 1'b0; avm_waitrequest = 1'b1;

    // 6: strict FIFO instance keeps both stores; coalescing one merges
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    push(32'h400, 32'h110000AA, 4'b1001);
    push(32'h400, 32'h0000BBCC, 4'b0011);
    chk("t6_nc_count", nc_count, 2);
    chk("t6_c_count", count, 1);
    snoop(32'h400);
    chk("t6_nc_snoop_be", nc_snoop_byteenable, 4'b1011);
    chk("t6_nc_snoop_data", nc_snoop_data, 32'h1100BBCC);
    chk("t6_c_snoop_data", snoop_data, 32'h1100BBCC);
    drain_en = 1'b1; avm_waitrequest = 1'b0;
    n_wr = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (nc_avm_write) begin
        if (n_wr < 4) begin wr_data[n_wr] = nc_avm_writedata; wr_be[n_wr] = nc_avm_byteenable; end
        n_wr++;
      end
    end
    chk("t6_nc_writes", n_wr, 2);
    chk("t6_nc_wr0_data", wr_data[0], 32'h110000AA);
    chk("t6_nc_wr0_be", wr_be[0], 4'b1001);
    chk("t6_nc_wr1_data", wr_data[1], 32'h0000BBCC);
    chk("t6_nc_wr1_be", wr_be[1], 4'b0011);
    chk("t6_nc_empty", nc_empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
